// File: rtl/fifo_package.sv
// Shared defaults for the SRAM-backed FIFO controller.
package fifo_package;

  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_ADDR_WIDTH = 4;

endpackage

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller in front of a single-port synchronous SRAM.
// Writes take the SRAM port whenever a push is accepted. Reads fill a
// one-entry registered output stage, so the head entry is stable on
// pop_data_o. An entry is always in exactly one place: the SRAM
// (sram_cnt), in flight from the SRAM (rd_pend), or in the output
// register (out_valid).
module sram_fifo_ctrl
  import fifo_package::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  push_valid_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  push_ready_o,
  output logic                  pop_valid_o,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  input  logic                  pop_ready_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic                  sram_we_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   sram_cnt;
  logic                  rd_pend;
  logic                  out_valid;

  logic push_fire;
  logic pop_fire;
  logic rd_issue;

  // Ready depends only on registered occupancy, never on the consumer.
  assign push_ready_o = (sram_cnt < DEPTH_C);
  assign push_fire    = push_valid_i & push_ready_o;
  assign pop_valid_o  = out_valid;
  assign pop_fire     = out_valid & pop_ready_i;

  // A read is launched only when the output slot will be free to catch it
  // and the port is not taken by a write.
  assign rd_issue = ~push_fire & (sram_cnt != '0) & ~rd_pend &
                    (~out_valid | pop_fire);

  assign count_o = sram_cnt
                 + {{ADDR_WIDTH{1'b0}}, rd_pend}
                 + {{ADDR_WIDTH{1'b0}}, out_valid};
  assign full_o  = (sram_cnt == DEPTH_C);
  assign empty_o = (count_o == '0);

  // SRAM port mux: an accepted write owns the port, otherwise it shows the read pointer.
  always_comb begin
    sram_we_o    = 1'b0;
    sram_addr_o  = rd_ptr;
    sram_wdata_o = '0;
    if (push_fire) begin
      sram_we_o    = 1'b1;
      sram_addr_o  = wr_ptr;
      sram_wdata_o = push_data_i;
    end
  end

  // Pointers and SRAM occupancy; push and read issue never coincide.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr   <= wr_ptr + ADDR_WIDTH'(1);
        sram_cnt <= sram_cnt + (ADDR_WIDTH+1)'(1);
      end else if (rd_issue) begin
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
        sram_cnt <= sram_cnt - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Read-data capture into the output register; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend    <= 1'b0;
      out_valid  <= 1'b0;
      pop_data_o <= '0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_pend) begin
        pop_data_o <= sram_rdata_i;
        out_valid  <= 1'b1;
      end else if (pop_fire) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule
